// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset main control: Moore-decoded datapath controls; lw 5, sw/R/addi 4, beq/j 3 cycles.
// Waits on mem_ready in FETCH, MEMRD and MEMWR (each stalled cycle adds one); retire/cycle counters wrap.
module mc_ctrl_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 write_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic                 illegal_op,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;
    logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic                   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_RTEXE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXE:  state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge leaving its final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
        instr_count_d = instr_count_q + {{(CNT_WIDTH-1){1'b0}}, retire};
        cycle_count_d = cycle_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        memtoreg      = 1'b0;
        regdst        = 1'b0;
        write_reg     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    write_reg = 1'b1;
                    memtoreg  = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_RTEXE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RTWB: begin
                    write_reg = 1'b1;
                    regdst    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: begin
                    write_reg = 1'b1;
                end
                default: begin
                    write_reg = 1'b0;
                end
            endcase
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: instruction-level reference model, random waits/resets,
// 32-bit and 4-bit counter instances driven in parallel.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        memtoreg, regdst, write_reg, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count, cycle_count;

    logic        pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4;
    logic        memtoreg4, regdst4, write_reg4, alu_src_a4, illegal_op4;
    logic [1:0]  alu_src_b4, alu_op4, pc_source4;
    logic [3:0]  state4;
    logic [3:0]  instr_count4, cycle_count4;

    mc_ctrl_fsm #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .memtoreg(memtoreg), .regdst(regdst), .write_reg(write_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    mc_ctrl_fsm #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .iord(iord4),
        .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
        .memtoreg(memtoreg4), .regdst(regdst4), .write_reg(write_reg4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .pc_source(pc_source4), .illegal_op(illegal_op4), .state(state4),
        .instr_count(instr_count4), .cycle_count(cycle_count4)
    );

    always #5 clk = ~clk;

    logic [16:0] act_ctrl, act_ctrl4;
    assign act_ctrl  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, memtoreg,
                        regdst, write_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    assign act_ctrl4 = {pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4, memtoreg4,
                        regdst4, write_reg4, alu_src_a4, alu_src_b4, alu_op4, pc_source4, illegal_op4};

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;
    // Architectural state numbers as shown on the debug port.
    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int RTEXE = 6, RTWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11;

    typedef struct {
        int          st;
        logic [16:0] ctrl;
        int          ic;
        int          cc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ic = 0;
    int   m_cc = 0;
    int   cyc_no = 0;

    function automatic bit is_legal(logic [5:0] opc);
        return opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    // Expected control word for one cycle, from the per-state control table.
    function automatic logic [16:0] exp_ctrl(int st, logic [5:0] opc, bit rdy, bit r);
        logic pcw, pcwc, io, mr, mw, irw, m2r, rd, wr, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, io, mr, mw, irw, m2r, rd, wr, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        if (!r) begin
            case (st)
                FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
                DECODE: begin asb = 2'b11; ill = !is_legal(opc); end
                MEMADR: begin asa = 1; asb = 2'b10; end
                MEMRD:  begin mr = 1; io = 1; end
                MEMWB:  begin wr = 1; m2r = 1; end
                MEMWR:  begin mw = 1; io = 1; end
                RTEXE:  begin asa = 1; aop = 2'b10; end
                RTWB:   begin wr = 1; rd = 1; end
                BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
                JUMP:   begin pcw = 1; psrc = 2'b10; end
                ADDIEX: begin asa = 1; asb = 2'b10; end
                ADDIWB: begin wr = 1; end
                default: ;
            endcase
        end
        return {pcw, pcwc, io, mr, mw, irw, m2r, rd, wr, asa, asb, aop, psrc, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_no, act, expv);
        end
    endtask

    // Monitor: every cycle the DUT presents a state/control word; compare against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", {28'd0, state}, e.st);
            chk("ctrl", {15'd0, act_ctrl}, {15'd0, e.ctrl});
            chk("ctrl_w4", {15'd0, act_ctrl4}, {15'd0, e.ctrl});
            chk("instr_count", instr_count, e.ic);
            chk("cycle_count", cycle_count, e.cc);
            chk("instr_count_w4", {28'd0, instr_count4}, e.ic % 16);
            chk("cycle_count_w4", {28'd0, cycle_count4}, e.cc % 16);
            cyc_no++;
        end
    end

    // Drive one cycle and push the expected view of that cycle; then advance the model.
    task automatic cyc(input int st, input logic [5:0] opc, input bit rdy, input bit r, input bit ret);
        exp_t e;
        rst       = r;
        opcode    = opc;
        mem_ready = rdy;
        e.st   = st;
        e.ctrl = exp_ctrl(st, opc, rdy, r);
        e.ic   = m_ic;
        e.cc   = m_cc;
        exp_q.push_back(e);
        if (r) begin
            m_ic = 0;
            m_cc = 0;
        end else begin
            m_cc++;
            if (ret) m_ic++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input int cur_st);
        for (int i = 0; i < n; i++) begin
            cyc((i == 0) ? cur_st : FETCH, 6'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
    endtask

    // One instruction as a list of architectural steps; abort_at injects reset at that step.
    task automatic run_instr(input int kind, input int fw, input int mw, input int abort_at);
        int         sts[$];
        bit         rdys[$];
        logic [5:0] opc;
        case (kind)
            K_R:    opc = OP_R;
            K_LW:   opc = OP_LW;
            K_SW:   opc = OP_SW;
            K_BEQ:  opc = OP_BEQ;
            K_J:    opc = OP_J;
            K_ADDI: opc = OP_ADDI;
            default: begin
                opc = 6'($urandom);
                while (is_legal(opc)) opc = 6'($urandom);
            end
        endcase
        for (int i = 0; i < fw; i++) begin sts.push_back(FETCH); rdys.push_back(1'b0); end
        sts.push_back(FETCH);  rdys.push_back(1'b1);
        sts.push_back(DECODE); rdys.push_back(1'($urandom));
        case (kind)
            K_LW: begin
                sts.push_back(MEMADR); rdys.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin sts.push_back(MEMRD); rdys.push_back(1'b0); end
                sts.push_back(MEMRD); rdys.push_back(1'b1);
                sts.push_back(MEMWB); rdys.push_back(1'($urandom));
            end
            K_SW: begin
                sts.push_back(MEMADR); rdys.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin sts.push_back(MEMWR); rdys.push_back(1'b0); end
                sts.push_back(MEMWR); rdys.push_back(1'b1);
            end
            K_R:    begin sts.push_back(RTEXE);  rdys.push_back(1'($urandom));
                          sts.push_back(RTWB);   rdys.push_back(1'($urandom)); end
            K_ADDI: begin sts.push_back(ADDIEX); rdys.push_back(1'($urandom));
                          sts.push_back(ADDIWB); rdys.push_back(1'($urandom)); end
            K_BEQ:  begin sts.push_back(BRANCH); rdys.push_back(1'($urandom)); end
            K_J:    begin sts.push_back(JUMP);   rdys.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            logic [5:0] o;
            o = (sts[i] == FETCH) ? 6'($urandom) : opc;
            if (i == abort_at) begin
                do_reset(1, sts[i]);
                return;
            end
            cyc(sts[i], o, rdys[i], 1'b0, (i == sts.size() - 1) && (kind != K_ILL));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset(2, FETCH);
        run_instr(K_R, 0, 0, -1);
        run_instr(K_LW, 0, 2, -1);
        run_instr(K_SW, 3, 0, -1);
        run_instr(K_BEQ, 0, 0, -1);
        run_instr(K_J, 0, 0, -1);
        run_instr(K_ILL, 0, 0, -1);
        run_instr(K_LW, 0, 2, 4);
        for (int i = 0; i < 16; i++) run_instr(K_R, 0, 0, -1);
        for (int i = 0; i < 250; i++) begin
            int ab;
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), ab);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS-subset main control unit.
- Sequences each instruction through fetch / decode / execute / memory / writeback states.
- Drives the register-file write controls (write_reg, regdst, memtoreg) consumed by the register-file wrapper, plus the PC, memory, IR and ALU-source controls.
- Sits between the instruction register (opcode source) and all datapath stages; also keeps retired-instruction and cycle counters.

Parameters:
CNT_WIDTH, 32, width of instr_count and cycle_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  ir_data[31:26] from instruction register
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
iord  output  1  memory address select: 0=PC, 1=ALU out
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
memtoreg  output  1  regfile write data: 1=DR, 0=ALU out
regdst  output  1  regfile write index: 1=rd, 0=rt
write_reg  output  1  regfile write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decode
pc_source  output  2  00=ALU, 01=ALU out reg, 10=jump target
illegal_op  output  1  one-cycle pulse on undecodable opcode
state  output  4  current state, debug
instr_count  output  CNT_WIDTH  retired instructions
cycle_count  output  CNT_WIDTH  cycles since reset

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- Reset: on a clk edge with rst=1, state<=FETCH and both counters<=0.
- While rst=1, all control outputs and illegal_op are forced to 0 combinationally.
- Control outputs are Moore-decoded from state. Outputs not listed for a state are 0.
- FETCH: mem_read=1, alu_src_b=01.
  - ir_write and pc_write are 1 only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11. Next state by opcode:
  - 000000 -> RTEXE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - anything else: illegal_op=1 this cycle, next state FETCH, no retire.
- MEMADR: alu_src_a=1, alu_src_b=10. Next: lw -> MEMRD, sw -> MEMWR. The opcode is re-read here; IR is stable.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: write_reg=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready=1, then goes to FETCH.
- RTEXE: alu_src_a=1, alu_op=10. Next RTWB.
- RTWB: write_reg=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Next ADDIWB.
- ADDIWB: write_reg=1, regdst=0, memtoreg=0. Next FETCH.
- Instruction latency in cycles (with mem_ready=1 on first request):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each extra wait cycle adds 1.
- write_reg is asserted for exactly one cycle per lw, R-type or addi, and never in any other state.
- instr_count increments by 1 on the edge leaving MEMWB, RTWB, ADDIWB, BRANCH or JUMP, and on the edge leaving MEMWR when mem_ready=1.
- cycle_count increments every non-reset cycle.
- Both counters wrap modulo 2^CNT_WIDTH with no saturation.
- A reset asserted mid-instruction aborts it: no retire count and no further writes. The first cycle after rst drops is FETCH.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset then R-type: rst=1 for 2 cycles; check all controls 0 and counters 0. Then opcode=000000, mem_ready=1: state sequence 0,1,6,7,0; write_reg=1 and regdst=1 only in state 7; instr_count=1 after 4 cycles.
- lw with 2 wait cycles in MEMRD: opcode=100011; sequence 0,1,2,3,3,3,4,0; memtoreg=1 and write_reg=1 only in state 4; iord=1 in state 3; instr_count=1.
- sw with fetch wait: mem_ready=0 for 3 cycles in FETCH. ir_write and pc_write stay 0 during the wait and are 1 for one cycle when mem_ready=1. Then sequence 1,2,5,0; mem_write=1 in state 5; write_reg never 1.
- beq, then j, then opcode=111111:
  - beq: pc_write_cond=1, alu_op=01 in state 8.
  - j: pc_write=1, pc_source=10 in state 9.
  - Illegal opcode: illegal_op pulses once in DECODE, next state 0, instr_count unchanged (2).
- Reset mid-lw: rst=1 while in MEMRD; next state 0, write_reg never asserted, counters read 0.
- Counter wrap with CNT_WIDTH=4: run 16 R-type instructions; instr_count returns to 0 and cycle_count wraps without glitch.
